fres_hist: RTL and testbench

FRES_HIST -- requirements
Module: fres_hist

---
 rtl/fres_hist.sv | 127 ++++++++++++
 tb/tb_fres_hist.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fres_hist.sv
// Result history for the FP ALU: captures {flags, result} on each valid_in rising edge
// into a small ring buffer and presents the selected entry, one 16-bit page at a time, on led.
module fres_hist #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] result_in,
  input  logic [4:0]  flags_in,
  input  logic        clear,
  input  logic        btn_prev,
  input  logic        btn_next,
  output logic [15:0] led,
  output logic [4:0]  count,
  output logic        empty,
  output logic        full
);

  localparam int         PW      = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic vin_p0, prev_p0, next_p0;
  logic cap_ev, prev_ev, next_ev;

  logic [36:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [PW-1:0] sel, sel_nxt;
  logic [1:0]    page, page_nxt;
  logic [4:0]    count_nxt;
  logic          we;

  logic [PW-1:0] rd_idx;
  logic [36:0]   rd_word;
  logic [2:0]    sel_lo;
  logic [15:0]   led_nxt;

  // Stage p0: previous-sample registers; loaded high in reset so held inputs raise no event
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vin_p0  <= 1'b1;
      prev_p0 <= 1'b1;
      next_p0 <= 1'b1;
    end else begin
      vin_p0  <= valid_in;
      prev_p0 <= btn_prev;
      next_p0 <= btn_next;
    end
  end

  assign cap_ev  = valid_in & ~vin_p0;
  assign prev_ev = btn_prev & ~prev_p0;
  assign next_ev = btn_next & ~next_p0;

  // One event per cycle wins: clear, then capture, then prev, then next
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    sel_nxt    = sel;
    page_nxt   = page;
    count_nxt  = count;
    we         = 1'b0;
    if (clear) begin
      wr_ptr_nxt = '0;
      sel_nxt    = '0;
      page_nxt   = 2'd0;
      count_nxt  = 5'd0;
    end else if (cap_ev) begin
      we         = 1'b1;
      wr_ptr_nxt = wr_ptr + PW'(1);
      sel_nxt    = '0;
      page_nxt   = 2'd0;
      if (count != DEPTH_C)
        count_nxt = count + 5'd1;
    end else if (prev_ev && count != 5'd0) begin
      page_nxt = 2'd0;
      if (5'(sel) < count - 5'd1)
        sel_nxt = sel + PW'(1);
      else
        sel_nxt = '0;
    end else if (next_ev && count != 5'd0) begin
      page_nxt = (page == 2'd2) ? 2'd0 : page + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && we)
      mem[wr_ptr] <= {flags_in, result_in};
  end

  // Display mux works from the registered state, so led trails state by one edge
  assign rd_idx  = wr_ptr - PW'(1) - sel;
  assign rd_word = mem[rd_idx];
  assign sel_lo  = 3'(sel);

  always_comb begin
    led_nxt = 16'h0000;
    if (count != 5'd0) begin
      case (page)
        2'd0:    led_nxt = rd_word[15:0];
        2'd1:    led_nxt = rd_word[31:16];
        default: led_nxt = {rd_word[36:32], 1'b1, 7'b0, sel_lo};
      endcase
    end
  end

  // Stage p1: control and display registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      sel    <= '0;
      page   <= 2'd0;
      count  <= 5'd0;
      empty  <= 1'b1;
      full   <= 1'b0;
      led    <= 16'h0000;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      sel    <= sel_nxt;
      page   <= page_nxt;
      count  <= count_nxt;
      empty  <= (count_nxt == 5'd0);
      full   <= (count_nxt == DEPTH_C);
      led    <= led_nxt;
    end
  end

endmodule

// File: tb/tb_fres_hist.sv
// Directed bench for fres_hist: table of per-cycle vectors plus a reset-while-browsing sequence.
module tb_fres_hist;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] result_in = 32'h0;
  logic [4:0]  flags_in = 5'h0;
  logic        clear = 1'b0;
  logic        btn_prev = 1'b0;
  logic        btn_next = 1'b0;
  logic [15:0] led;
  logic [4:0]  count;
  logic        empty;
  logic        full;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fres_hist #(.DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .result_in(result_in),
    .flags_in (flags_in),
    .clear    (clear),
    .btn_prev (btn_prev),
    .btn_next (btn_next),
    .led      (led),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic [4:0]  fl;
    logic        clr;
    logic        prv;
    logic        nxt;
    logic [15:0] e_led;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [31:0] res, input logic [4:0] fl,
                     input logic clr, input logic prv, input logic nxt,
                     input logic [15:0] e_led, input logic [4:0] e_cnt);
    vec_t r;
    r.v = v; r.res = res; r.fl = fl; r.clr = clr; r.prv = prv; r.nxt = nxt;
    r.e_led = e_led; r.e_cnt = e_cnt;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_led, input logic [4:0] e_cnt);
    chk({tag, " led"},   32'(led),   32'(e_led));
    chk({tag, " count"}, 32'(count), 32'(e_cnt));
    chk({tag, " empty"}, 32'(empty), 32'(e_cnt == 5'd0));
    chk({tag, " full"},  32'(full),  32'(e_cnt == 5'd8));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // REQ-032 style: single capture, then page through it
    add(1, 32'h3F800000, 5'h0, 0, 0, 0, 16'h0000, 5'd1);
    add(0, 32'h0, 5'h0, 0, 0, 0, 16'h0000, 5'd1);
    add(0, 32'h0, 5'h0, 0, 0, 1, 16'h0000, 5'd1);
    add(0, 32'h0, 5'h0, 0, 0, 0, 16'h3F80, 5'd1);
    add(0, 32'h0, 5'h0, 0, 0, 1, 16'h3F80, 5'd1);
    add(0, 32'h0, 5'h0, 0, 0, 0, 16'h0400, 5'd1);
    add(0, 32'h0, 5'h0, 0, 0, 1, 16'h0400, 5'd1);
    add(0, 32'h0, 5'h0, 0, 0, 0, 16'h0000, 5'd1);
    // valid_in held high: one capture only
    add(0, 32'h0, 5'h0, 1, 0, 0, 16'h0000, 5'd0);
    for (int i = 0; i < 5; i++)
      add(1, 32'h40000000, 5'h0, 0, 0, 0, 16'h0000, 5'd1);
    add(0, 32'h0, 5'h0, 0, 0, 1, 16'h0000, 5'd1);
    add(0, 32'h0, 5'h0, 0, 0, 0, 16'h4000, 5'd1);
    // nine captures into eight entries, then browse back with wrap
    add(0, 32'h0, 5'h0, 1, 0, 0, 16'h4000, 5'd0);
    for (int k = 1; k <= 9; k++) begin
      add(1, 32'(k), 5'h0, 0, 0, 0, (k == 1) ? 16'h0 : 16'(k - 1), 5'((k > 8) ? 8 : k));
      add(0, 32'h0, 5'h0, 0, 0, 0, 16'(k), 5'((k > 8) ? 8 : k));
    end
    for (int j = 1; j <= 8; j++) begin
      add(0, 32'h0, 5'h0, 0, 1, 0, 16'(9 - (j - 1)), 5'd8);
      add(0, 32'h0, 5'h0, 0, 0, 0, 16'(9 - ((j == 8) ? 0 : j)), 5'd8);
    end
    // clear beats capture in the same cycle
    add(1, 32'h00000077, 5'h0, 1, 0, 0, 16'h0009, 5'd0);
    add(0, 32'h0, 5'h0, 0, 0, 0, 16'h0000, 5'd0);
    // flags page and sel display
    add(1, 32'h12345678, 5'b10001, 0, 0, 0, 16'h0000, 5'd1);
    add(0, 32'h0, 5'h0, 0, 0, 0, 16'h5678, 5'd1);
    add(0, 32'h0, 5'h0, 0, 0, 1, 16'h5678, 5'd1);
    add(0, 32'h0, 5'h0, 0, 0, 0, 16'h1234, 5'd1);
    add(0, 32'h0, 5'h0, 0, 0, 1, 16'h1234, 5'd1);
    add(0, 32'h0, 5'h0, 0, 0, 0, 16'h8C00, 5'd1);
    add(1, 32'hAAAA5555, 5'h0, 0, 0, 0, 16'h8C00, 5'd2);
    add(0, 32'h0, 5'h0, 0, 0, 0, 16'h5555, 5'd2);
    add(0, 32'h0, 5'h0, 0, 1, 0, 16'h5555, 5'd2);
    add(0, 32'h0, 5'h0, 0, 0, 0, 16'h5678, 5'd2);
    add(0, 32'h0, 5'h0, 0, 0, 1, 16'h5678, 5'd2);
    add(0, 32'h0, 5'h0, 0, 0, 0, 16'h1234, 5'd2);
    add(0, 32'h0, 5'h0, 0, 0, 1, 16'h1234, 5'd2);
    add(0, 32'h0, 5'h0, 0, 0, 0, 16'h8C01, 5'd2);
    // capture discards prev; prev discards next
    add(1, 32'h0000CAFE, 5'h0, 0, 1, 0, 16'h8C01, 5'd3);
    add(0, 32'h0, 5'h0, 0, 0, 0, 16'hCAFE, 5'd3);
    add(0, 32'h0, 5'h0, 0, 1, 1, 16'hCAFE, 5'd3);
    add(0, 32'h0, 5'h0, 0, 0, 0, 16'h5555, 5'd3);

    rst_n = 1'b0;
    cyc();
    cyc();
    chk_all("reset", 16'h0000, 5'd0);
    rst_n = 1'b1;
    cyc();
    chk_all("idle", 16'h0000, 5'd0);

    foreach (tbl[i]) begin
      valid_in  = tbl[i].v;
      result_in = tbl[i].res;
      flags_in  = tbl[i].fl;
      clear     = tbl[i].clr;
      btn_prev  = tbl[i].prv;
      btn_next  = tbl[i].nxt;
      cyc();
      chk_all($sformatf("row%0d", i), tbl[i].e_led, tbl[i].e_cnt);
    end

    // Reset mid-browse (sel 1 -> 2) with btn_prev and valid_in held across release
    btn_prev = 1'b1;
    cyc();
    chk_all("browse sel2", 16'h5555, 5'd3);
    valid_in  = 1'b1;
    result_in = 32'hDEAD0000;
    rst_n     = 1'b0;
    cyc();
    chk_all("rst hold 1", 16'h0000, 5'd0);
    cyc();
    chk_all("rst hold 2", 16'h0000, 5'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_all($sformatf("post rst %0d", i), 16'h0000, 5'd0);
    end
    valid_in = 1'b0;
    cyc();
    valid_in  = 1'b1;
    result_in = 32'h00001111;
    cyc();
    chk_all("held prev cap1", 16'h0000, 5'd1);
    valid_in = 1'b0;
    cyc();
    cyc();
    chk_all("held prev show1", 16'h1111, 5'd1);
    valid_in  = 1'b1;
    result_in = 32'h00002222;
    cyc();
    valid_in = 1'b0;
    cyc();
    cyc();
    chk_all("held prev show2", 16'h2222, 5'd2);
    btn_prev = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
